// File: rtl/int_sq_window_tp1.sv
// 9-tap sliding window over the channels of a line, squaring each tap for a
// downstream sum. Each line of N channels yields N outputs; taps outside the
// line read zero. After the last channel the window is flushed with four zero
// shifts so the final channels reach the centre tap.
module int_sq_window_tp1 #(
  parameter int unsigned pINT8_BW = 9
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  din_pvld,
  output logic                  din_prdy,
  input  logic [pINT8_BW-1:0]   din_pd,
  input  logic                  din_last,
  input  logic [1:0]            reg2dp_normalz_len,
  output logic [pINT8_BW*2-2:0] sq_pd_int8_0,
  output logic [pINT8_BW*2-2:0] sq_pd_int8_1,
  output logic [pINT8_BW*2-2:0] sq_pd_int8_2,
  output logic [pINT8_BW*2-2:0] sq_pd_int8_3,
  output logic [pINT8_BW*2-2:0] sq_pd_int8_4,
  output logic [pINT8_BW*2-2:0] sq_pd_int8_5,
  output logic [pINT8_BW*2-2:0] sq_pd_int8_6,
  output logic [pINT8_BW*2-2:0] sq_pd_int8_7,
  output logic [pINT8_BW*2-2:0] sq_pd_int8_8,
  output logic                  load_din_d,
  output logic                  load_din_2d,
  output logic                  len5,
  output logic                  len7,
  output logic                  len9,
  output logic                  sum_pvld
);

  localparam int unsigned SqW = 2 * pINT8_BW - 1;

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e              state_q, state_d;
  logic [pINT8_BW-1:0] win_q [9];
  logic [pINT8_BW-1:0] win_d [9];
  logic [2:0]          pend_q, pend_d;   // outputs still owed for the current line (0..4)
  logic [1:0]          fcnt_q, fcnt_d;   // flush shift index (0..3)
  logic [1:0]          len_q, len_d;
  logic                load_d_q, load_2d_q, sum_pvld_q;
  logic                accept;
  logic                emit;
  logic [2:0]          flush_rem;
  logic [SqW-1:0]      sq [9];

  assign accept    = din_pvld & din_prdy;
  // Shifts left in the flush including this one; the last pend_q of them emit.
  assign flush_rem = 3'd4 - {1'b0, fcnt_q};

  // FSM state register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = din_last ? StFlush : StRun;
      StRun:   if (accept && din_last) state_d = StFlush;
      StFlush: if (fcnt_q == 2'd3) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: handshake, emit flag and window/counter next state.
  always_comb begin
    din_prdy = (state_q != StFlush);
    emit     = 1'b0;
    win_d    = win_q;
    pend_d   = pend_q;
    fcnt_d   = fcnt_q;
    len_d    = len_q;
    unique case (state_q)
      StIdle: begin
        // Outside a line the window is zero; a line start loads only win[8].
        for (int k = 0; k < 9; k++) win_d[k] = '0;
        if (accept) begin
          win_d[8] = din_pd;
          pend_d   = 3'd1;
          fcnt_d   = 2'd0;
          len_d    = reg2dp_normalz_len;
        end
      end
      StRun: begin
        if (accept) begin
          for (int k = 0; k < 8; k++) win_d[k] = win_q[k+1];
          win_d[8] = din_pd;
          fcnt_d   = 2'd0;
          if (pend_q == 3'd4) emit = 1'b1;
          else pend_d = pend_q + 3'd1;
        end
      end
      StFlush: begin
        for (int k = 0; k < 8; k++) win_d[k] = win_q[k+1];
        win_d[8] = '0;
        fcnt_d   = fcnt_q + 2'd1;
        if (flush_rem <= pend_q) begin
          emit   = 1'b1;
          pend_d = pend_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Window, counters, latched length and the emit strobe pipeline.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
      pend_q     <= 3'd0;
      fcnt_q     <= 2'd0;
      len_q      <= 2'd0;
      load_d_q   <= 1'b0;
      load_2d_q  <= 1'b0;
      sum_pvld_q <= 1'b0;
    end else begin
      win_q      <= win_d;
      pend_q     <= pend_d;
      fcnt_q     <= fcnt_d;
      len_q      <= len_d;
      load_d_q   <= emit;
      load_2d_q  <= load_d_q;
      sum_pvld_q <= load_2d_q;
    end
  end

  // Square via magnitude so the most negative input squares without overflow.
  for (genvar k = 0; k < 9; k++) begin : gen_sq
    logic [pINT8_BW-1:0] mag;
    logic [SqW-1:0]      mag_x;
    assign mag   = win_q[k][pINT8_BW-1] ?
                   (~win_q[k]) + {{(pINT8_BW-1){1'b0}}, 1'b1} : win_q[k];
    assign mag_x = {{(SqW-pINT8_BW){1'b0}}, mag};
    assign sq[k] = mag_x * mag_x;
  end

  assign sq_pd_int8_0 = sq[0];
  assign sq_pd_int8_1 = sq[1];
  assign sq_pd_int8_2 = sq[2];
  assign sq_pd_int8_3 = sq[3];
  assign sq_pd_int8_4 = sq[4];
  assign sq_pd_int8_5 = sq[5];
  assign sq_pd_int8_6 = sq[6];
  assign sq_pd_int8_7 = sq[7];
  assign sq_pd_int8_8 = sq[8];

  assign load_din_d  = load_d_q;
  assign load_din_2d = load_2d_q;
  assign sum_pvld    = sum_pvld_q;
  assign len5        = (len_q == 2'd1);
  assign len7        = (len_q == 2'd2);
  assign len9        = (len_q == 2'd3);

endmodule
